// File: rtl/sr_trace_pkg.sv
// sr_trace_pkg: shared types and default parameter values for the trace monitor.
package sr_trace_pkg;

  localparam int DEFAULT_PC_W        = 32;
  localparam int DEFAULT_INSTR_W     = 32;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_CNT_W       = 32;
  localparam int DEFAULT_CYCLE_LIMIT = 150;
  localparam int DEFAULT_OVERWRITE   = 1;

  // One trace entry at default widths. Storage packs fields in this same
  // order: pc in the MSBs, then instr, then the optional branch-miss bit.
  typedef struct packed {
    logic [DEFAULT_PC_W-1:0]    pc;
    logic [DEFAULT_INSTR_W-1:0] instr;
    logic                       br_miss;
  } trace_entry_t;

  // Width of one stored entry; the miss bit exists only with branch stats.
  function automatic int entry_width(input int pc_w, input int instr_w, input bit stat_en);
    return pc_w + instr_w + (stat_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/sr_trace_ram.sv
// sr_trace_ram: DEPTH x WIDTH simple dual-port memory, synchronous write,
// registered read. A read and a write to the same address in the same cycle
// return the old contents, which lets a full buffer pop and refill one slot.
module sr_trace_ram
  import sr_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 65,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register; cleared by reset so read-side outputs start at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sr_trace_monitor.sv
// sr_trace_monitor: decode-stage instruction trace buffer with overflow and
// timeout handling plus saturating cycle/instruction/branch-miss statistics.
// Optional feature macro: SR_TRACE_BRANCH_STAT_EN (store br_miss, count misses).
module sr_trace_monitor
  import sr_trace_pkg::*;
#(
  parameter int PC_W        = DEFAULT_PC_W,
  parameter int INSTR_W     = DEFAULT_INSTR_W,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT,
  parameter int OVERWRITE   = DEFAULT_OVERWRITE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               br_miss,
  input  logic               freeze,
  input  logic               rd_req,
  output logic               rd_vld,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               rd_miss,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef SR_TRACE_BRANCH_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif
  localparam int              EW       = entry_width(PC_W, INSTR_W, STAT_EN);
  localparam logic [AW:0]     OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit              OW_EN    = (OVERWRITE != 0);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   occ;
  logic          at_limit;
  logic          halt;
  logic          cap;
  logic          pop;
  logic          wr_en;
  logic          rd_adv;
  logic          ovf_evt;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  // at_limit anticipates timeout by one cycle so the cycle counter stops
  // exactly at the limit and no capture slips in on the setting edge.
  if (CYCLE_LIMIT == 0) begin : g_no_limit
    assign at_limit = 1'b0;
  end else begin : g_limit
    assign at_limit = (cycle_cnt == CNT_W'(CYCLE_LIMIT));
  end

  assign halt    = timeout | at_limit;
  assign cap     = vld & ~freeze & ~halt;
  assign empty   = (occ == '0);
  assign full    = (occ == OCC_FULL);
  assign pop     = rd_req & ~empty;
  // A full buffer accepts a capture when a pop frees a slot or overwrite is on.
  assign wr_en   = cap & (~full | pop | OW_EN);
  // Overwrite discards the oldest entry by moving the read pointer past it.
  assign rd_adv  = pop | (cap & full & OW_EN);
  assign ovf_evt = cap & full & ~pop;

  // Pointers, occupancy, sticky flags and read-valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (rd_adv) rptr <= rptr + 1'b1;
      if (wr_en && !pop && !full)  occ <= occ + 1'b1;
      else if (pop && !wr_en)      occ <= occ - 1'b1;
      if (ovf_evt)  overflow <= 1'b1;
      if (at_limit) timeout  <= 1'b1;
      rd_vld <= pop;
    end
  end

  // Saturating cycle and instruction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (!halt && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
      if (cap && instr_cnt != CNT_MAX)   instr_cnt <= instr_cnt + 1'b1;
    end
  end

`ifdef SR_TRACE_BRANCH_STAT_EN
  assign wdata   = {pc, instr, br_miss};
  assign rd_miss = rdata[0];

  // Saturating branch-miss counter, gated like captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     miss_cnt <= '0;
    else if (cap && br_miss && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
  end
`else
  logic unused_br_miss;
  assign unused_br_miss = br_miss;
  assign wdata    = {pc, instr};
  assign rd_miss  = 1'b0;
  assign miss_cnt = '0;
`endif

  assign rd_pc    = rdata[EW-1 -: PC_W];
  assign rd_instr = rdata[EW-PC_W-1 -: INSTR_W];

  sr_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wdata),
    .re    (pop),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sr_trace_monitor.sv
// tb_sr_trace_monitor: four monitor configurations driven by shared stimulus and
// checked against a queue-based reference model.
module tb_sr_trace_monitor;

  localparam int NI = 4;
  localparam int DEP [NI] = '{16, 4, 4, 4};
  localparam int OW  [NI] = '{1, 1, 0, 1};
  localparam int LIM [NI] = '{150, 0, 0, 10};
  localparam int CW  [NI] = '{32, 4, 32, 32};
`ifdef SR_TRACE_BRANCH_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          miss;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, br_miss, freeze, rd_req;
  logic [31:0] pc, instr;

  logic        rd_vld_o [NI];
  logic [31:0] rd_pc_o [NI];
  logic [31:0] rd_instr_o [NI];
  logic        rd_miss_o [NI];
  logic        empty_o [NI];
  logic        full_o [NI];
  logic        ovf_o [NI];
  logic        to_o [NI];
  logic [31:0] cyc_o [NI];
  logic [31:0] icnt_o [NI];
  logic [31:0] mcnt_o [NI];

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t            mq [NI][$];
  bit              m_rv [NI];
  logic [31:0]     m_rpc [NI];
  logic [31:0]     m_rinstr [NI];
  bit              m_rmiss [NI];
  bit              m_ovf [NI];
  bit              m_to [NI];
  longint unsigned m_cyc [NI];
  longint unsigned m_icnt [NI];
  longint unsigned m_mcnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CW[g]-1:0] cc, ic, mc;
    sr_trace_monitor #(
      .PC_W(32), .INSTR_W(32), .DEPTH(DEP[g]), .CNT_W(CW[g]),
      .CYCLE_LIMIT(LIM[g]), .OVERWRITE(OW[g])
    ) u_dut (
      .clk(clk), .rst(rst), .vld(vld), .pc(pc), .instr(instr),
      .br_miss(br_miss), .freeze(freeze), .rd_req(rd_req),
      .rd_vld(rd_vld_o[g]), .rd_pc(rd_pc_o[g]), .rd_instr(rd_instr_o[g]),
      .rd_miss(rd_miss_o[g]), .empty(empty_o[g]), .full(full_o[g]),
      .overflow(ovf_o[g]), .timeout(to_o[g]),
      .cycle_cnt(cc), .instr_cnt(ic), .miss_cnt(mc)
    );
    assign cyc_o[g]  = 32'(cc);
    assign icnt_o[g] = 32'(ic);
    assign mcnt_o[g] = 32'(mc);
  end

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      m_rv[i] = 0; m_rpc[i] = '0; m_rinstr[i] = '0; m_rmiss[i] = 0;
      m_ovf[i] = 0; m_to[i] = 0; m_cyc[i] = 0; m_icnt[i] = 0; m_mcnt[i] = 0;
    end
  endtask

  // One clock edge of the behavioural model using the current inputs.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      longint unsigned maxc;
      bit lim_hit, stop, c, p;
      ent_t e;
      maxc    = (64'd1 << CW[i]) - 1;
      lim_hit = (LIM[i] != 0) && (m_cyc[i] == longint'(LIM[i]));
      stop    = m_to[i] || lim_hit;
      c       = vld && !freeze && !stop;
      p       = rd_req && (mq[i].size() > 0);
      m_rv[i] = p;
      if (p) begin
        e = mq[i].pop_front();
        m_rpc[i] = e.pc; m_rinstr[i] = e.instr; m_rmiss[i] = STAT && e.miss;
      end
      if (c) begin
        e.pc = pc; e.instr = instr; e.miss = br_miss;
        if (mq[i].size() < DEP[i]) mq[i].push_back(e);
        else begin
          m_ovf[i] = 1;
          if (OW[i] != 0) begin
            void'(mq[i].pop_front());
            mq[i].push_back(e);
          end
        end
      end
      if (!stop && m_cyc[i] < maxc) m_cyc[i]++;
      if (c && m_icnt[i] < maxc) m_icnt[i]++;
      if (STAT && c && br_miss && m_mcnt[i] < maxc) m_mcnt[i]++;
      if (lim_hit) m_to[i] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    vld = 0; br_miss = 0; freeze = 0; rd_req = 0; pc = '0; instr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
  endtask

  task automatic capture(input logic [31:0] p, input bit miss);
    vld = 1; pc = p; instr = $urandom(); br_miss = miss; rd_req = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) capture(32'(k * 4), 1'b0);
    vld = 0; rd_req = 1;
    tick();
    rd_req = 0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({rd_vld_o[i], empty_o[i], full_o[i], ovf_o[i], to_o[i]} !== 5'b01000) begin
        errors++;
        $display("FAIL reset_flags inst%0d got %b want 01000", i,
                 {rd_vld_o[i], empty_o[i], full_o[i], ovf_o[i], to_o[i]});
      end
      checks++;
      if ({cyc_o[i], icnt_o[i], mcnt_o[i], rd_pc_o[i], rd_instr_o[i], rd_miss_o[i]} !== '0) begin
        errors++;
        $display("FAIL reset_values inst%0d cyc %0d icnt %0d mcnt %0d rd_pc %h rd_instr %h rd_miss %b want all 0",
                 i, cyc_o[i], icnt_o[i], mcnt_o[i], rd_pc_o[i], rd_instr_o[i], rd_miss_o[i]);
      end
    end
    model_reset();
    #3;
    rst = 1'b0;
    rd_req = 1;
    tick();
    rd_req = 0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rd_vld_o[i] !== 1'b0 || empty_o[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_discard inst%0d rd_vld %b empty %b want 0 1", i, rd_vld_o[i], empty_o[i]);
      end
    end
  endtask

  task automatic test_fifo_order();
    do_reset();
    for (int k = 0; k < 5; k++) capture(32'(k * 4), 1'b0);
    vld = 0;
    for (int k = 0; k < 5; k++) begin
      rd_req = 1;
      tick();
      checks++;
      if (rd_vld_o[0] !== 1'b1 || rd_pc_o[0] !== 32'(k * 4) || rd_instr_o[0] !== m_rinstr[0]) begin
        errors++;
        $display("FAIL fifo_read%0d got vld %b pc %h instr %h want 1 %h %h", k,
                 rd_vld_o[0], rd_pc_o[0], rd_instr_o[0], 32'(k * 4), m_rinstr[0]);
      end
    end
    rd_req = 0;
    tick();
    checks++;
    if (empty_o[0] !== 1'b1 || rd_vld_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL fifo_empty got empty %b rd_vld %b want 1 0", empty_o[0], rd_vld_o[0]);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int k = 0; k < 6; k++) capture(32'(k * 4), 1'b0);
    vld = 0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (ovf_o[i] !== 1'b1 || full_o[i] !== 1'b1 || icnt_o[i] !== 32'd6) begin
        errors++;
        $display("FAIL overflow_state inst%0d ovf %b full %b icnt %0d want 1 1 6",
                 i, ovf_o[i], full_o[i], icnt_o[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      rd_req = 1;
      tick();
      checks++;
      if (rd_vld_o[1] !== 1'b1 || rd_pc_o[1] !== 32'(8 + 4 * k)) begin
        errors++;
        $display("FAIL overwrite_read%0d got vld %b pc %h want 1 %h", k, rd_vld_o[1], rd_pc_o[1], 32'(8 + 4 * k));
      end
      checks++;
      if (rd_vld_o[2] !== 1'b1 || rd_pc_o[2] !== 32'(4 * k)) begin
        errors++;
        $display("FAIL drop_read%0d got vld %b pc %h want 1 %h", k, rd_vld_o[2], rd_pc_o[2], 32'(4 * k));
      end
    end
    rd_req = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int t = 1; t <= 14; t++) begin
      int lim_t;
      vld = 1; pc = $urandom(); instr = $urandom();
      tick();
      lim_t = (t < 10) ? t : 10;
      checks++;
      if (to_o[3] !== (t >= 11) || cyc_o[3] !== 32'(lim_t) || icnt_o[3] !== 32'(lim_t)) begin
        errors++;
        $display("FAIL timeout_t%0d got to %b cyc %0d icnt %0d want %b %0d %0d",
                 t, to_o[3], cyc_o[3], icnt_o[3], t >= 11, lim_t, lim_t);
      end
    end
    vld = 0; rd_req = 1;
    tick();
    rd_req = 0;
    checks++;
    if (rd_vld_o[3] !== 1'b1 || rd_pc_o[3] !== m_rpc[3] || cyc_o[3] !== 32'd10) begin
      errors++;
      $display("FAIL timeout_read got vld %b pc %h cyc %0d want 1 %h 10", rd_vld_o[3], rd_pc_o[3], cyc_o[3], m_rpc[3]);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int k = 0; k < 4; k++) capture(32'(k * 4), 1'b0);
    vld = 1; pc = 32'd16; instr = $urandom(); rd_req = 1;
    tick();
    vld = 0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (rd_vld_o[i] !== 1'b1 || rd_pc_o[i] !== 32'd0 || full_o[i] !== 1'b1 || ovf_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL full_simul inst%0d vld %b pc %h full %b ovf %b want 1 0 1 0",
                 i, rd_vld_o[i], rd_pc_o[i], full_o[i], ovf_o[i]);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rd_vld_o[2] !== 1'b1 || rd_pc_o[2] !== 32'(4 * k)) begin
        errors++;
        $display("FAIL drain_read%0d got vld %b pc %h want 1 %h", k, rd_vld_o[2], rd_pc_o[2], 32'(4 * k));
      end
    end
    tick();
    rd_req = 0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (rd_vld_o[i] !== 1'b0 || empty_o[i] !== 1'b1 || rd_pc_o[i] !== 32'd16) begin
        errors++;
        $display("FAIL empty_read inst%0d vld %b empty %b pc %h want 0 1 10", i, rd_vld_o[i], empty_o[i], rd_pc_o[i]);
      end
    end
  endtask

  task automatic test_branch();
    bit want_miss [3];
    want_miss = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 3; k++) capture(32'(k * 4), want_miss[k]);
    vld = 0; br_miss = 0;
    checks++;
    if (mcnt_o[0] !== (STAT ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL miss_cnt got %0d want %0d", mcnt_o[0], STAT ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      rd_req = 1;
      tick();
      checks++;
      if (rd_vld_o[0] !== 1'b1 || rd_miss_o[0] !== (STAT && want_miss[k])) begin
        errors++;
        $display("FAIL rd_miss%0d got vld %b miss %b want 1 %b", k, rd_vld_o[0], rd_miss_o[0], STAT && want_miss[k]);
      end
    end
    rd_req = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 200; n++) begin
      vld     = ($urandom_range(0, 9) < 7);
      freeze  = ($urandom_range(0, 9) < 2);
      br_miss = ($urandom_range(0, 9) < 3);
      rd_req  = ($urandom_range(0, 9) < 4);
      pc      = $urandom();
      instr   = $urandom();
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (rd_vld_o[i] !== m_rv[i] ||
            {rd_pc_o[i], rd_instr_o[i], rd_miss_o[i]} !== {m_rpc[i], m_rinstr[i], m_rmiss[i]}) begin
          errors++;
          $display("FAIL rand_read n%0d inst%0d got %b %h %h %b want %b %h %h %b", n, i,
                   rd_vld_o[i], rd_pc_o[i], rd_instr_o[i], rd_miss_o[i],
                   m_rv[i], m_rpc[i], m_rinstr[i], m_rmiss[i]);
        end
        checks++;
        if ({empty_o[i], full_o[i], ovf_o[i], to_o[i]} !==
            {mq[i].size() == 0, mq[i].size() == DEP[i], m_ovf[i], m_to[i]}) begin
          errors++;
          $display("FAIL rand_status n%0d inst%0d got %b want %b", n, i,
                   {empty_o[i], full_o[i], ovf_o[i], to_o[i]},
                   {mq[i].size() == 0, mq[i].size() == DEP[i], m_ovf[i], m_to[i]});
        end
        checks++;
        if ({cyc_o[i], icnt_o[i], mcnt_o[i]} !== {32'(m_cyc[i]), 32'(m_icnt[i]), 32'(m_mcnt[i])}) begin
          errors++;
          $display("FAIL rand_counters n%0d inst%0d got %0d %0d %0d want %0d %0d %0d", n, i,
                   cyc_o[i], icnt_o[i], mcnt_o[i], m_cyc[i], m_icnt[i], m_mcnt[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_fifo_order();
    test_overwrite();
    test_timeout();
    test_full_simul();
    test_branch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
